// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the execute/LSU stages, the issue stage and the
// register file write port. The slave modport is the arbiter's view.
interface regfile_wb_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic             stall;
    logic             alu_valid;
    logic             alu_ready;
    logic [AW-1:0]    alu_addr;
    logic [WIDTH-1:0] alu_data;
    logic             lsu_valid;
    logic             lsu_ready;
    logic [AW-1:0]    lsu_addr;
    logic [WIDTH-1:0] lsu_data;
    logic             rsv_valid;
    logic [AW-1:0]    rsv_addr;
    logic             we_0;
    logic [AW-1:0]    wr_addr0;
    logic [WIDTH-1:0] wr_din0;
    logic [DEPTH-1:0] pending_mask;
    logic             rsv_conflict;

    modport master (
        output stall, alu_valid, alu_addr, alu_data,
               lsu_valid, lsu_addr, lsu_data, rsv_valid, rsv_addr,
        input  alu_ready, lsu_ready, we_0, wr_addr0, wr_din0,
               pending_mask, rsv_conflict
    );

    modport slave (
        input  stall, alu_valid, alu_addr, alu_data,
               lsu_valid, lsu_addr, lsu_data, rsv_valid, rsv_addr,
        output alu_ready, lsu_ready, we_0, wr_addr0, wr_din0,
               pending_mask, rsv_conflict
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU
// and the LSU, with a registered write path and a per-register pending
// scoreboard for the issue stage's hazard checks.
module regfile_wb_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input logic                clk,
    input logic                rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {SRC_ALU = 1'b0, SRC_LSU = 1'b1} src_e;

    src_e             last_grant;
    logic             alu_gnt;
    logic             lsu_gnt;
    logic             xfer;
    logic [AW-1:0]    xfer_addr;
    logic [WIDTH-1:0] xfer_data;
    logic [DEPTH-1:0] mask_next;
    logic             conflict_next;

    // Grant: single requester wins outright, a tie goes to the source that
    // was not granted last; nothing is granted while stalled or in reset.
    always_comb begin
        alu_gnt = !rst && !bus.stall && bus.alu_valid &&
                  (!bus.lsu_valid || last_grant == SRC_LSU);
        lsu_gnt = !rst && !bus.stall && bus.lsu_valid &&
                  (!bus.alu_valid || last_grant == SRC_ALU);
        xfer      = alu_gnt || lsu_gnt;
        xfer_addr = alu_gnt ? bus.alu_addr : bus.lsu_addr;
        xfer_data = alu_gnt ? bus.alu_data : bus.lsu_data;
    end

    assign bus.alu_ready = alu_gnt;
    assign bus.lsu_ready = lsu_gnt;

    // Scoreboard next state: a reservation beats a same-edge writeback
    // clear, and x0 is never tracked.
    always_comb begin
        // NOTE: every combinationally assigned variable gets a default at the
        // top of the block so no path can leave it unassigned (no latches).
        mask_next = '0;
        for (int i = 1; i < DEPTH; i++) begin
            mask_next[i] = (bus.rsv_valid && bus.rsv_addr == AW'(i)) ||
                           (bus.pending_mask[i] &&
                            !(xfer && xfer_addr == AW'(i)));
        end
        conflict_next = bus.rsv_valid && (bus.rsv_addr != '0) &&
                        bus.pending_mask[bus.rsv_addr] &&
                        !(xfer && xfer_addr == bus.rsv_addr);
    end

    // Registered write port, round-robin pointer, scoreboard and conflict pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.we_0         <= 1'b0;
            bus.wr_addr0     <= '0;
            bus.wr_din0      <= '0;
            bus.pending_mask <= '0;
            bus.rsv_conflict <= 1'b0;
            last_grant       <= SRC_LSU;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            bus.pending_mask <= mask_next;
            bus.rsv_conflict <= conflict_next;
            if (xfer) begin
                bus.we_0     <= (xfer_addr != '0);
                bus.wr_addr0 <= xfer_addr;
                bus.wr_din0  <= xfer_data;
                last_grant   <= alu_gnt ? SRC_ALU : SRC_LSU;
            end else begin
                bus.we_0     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: handshake, round-robin alternation,
// scoreboard set/clear ordering, x0 handling, conflict pulse, stall and reset.
module tb_regfile_wb_arbiter;
    localparam int WIDTH = 32;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_passed = 0;

    regfile_wb_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    regfile_wb_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle_inputs();
        bus.stall     = 1'b0;
        bus.alu_valid = 1'b0;
        bus.alu_addr  = '0;
        bus.alu_data  = '0;
        bus.lsu_valid = 1'b0;
        bus.lsu_addr  = '0;
        bus.lsu_data  = '0;
        bus.rsv_valid = 1'b0;
        bus.rsv_addr  = '0;
    endtask

    // Advance to one time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        #1 rst = 1'b1;
        #12;
        check("rst_we", bus.we_0, 0);
        check("rst_addr", bus.wr_addr0, 0);
        check("rst_din", bus.wr_din0, 0);
        check("rst_mask", bus.pending_mask, 0);
        check("rst_conflict", bus.rsv_conflict, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single ALU write
        bus.alu_valid = 1'b1; bus.alu_addr = 5; bus.alu_data = 32'hDEADBEEF;
        #1;
        check("t1_alu_ready", bus.alu_ready, 1);
        check("t1_lsu_ready", bus.lsu_ready, 0);
        step();
        bus.alu_valid = 1'b0;
        check("t1_we", bus.we_0, 1);
        check("t1_addr", bus.wr_addr0, 5);
        check("t1_din", bus.wr_din0, 32'hDEADBEEF);
        step();
        check("t1_we_off", bus.we_0, 0);
        check("t1_addr_hold", bus.wr_addr0, 5);

        // Both valid continuously: strict alternation starting with ALU
        do_reset();
        bus.alu_valid = 1'b1; bus.alu_addr = 1; bus.alu_data = 32'h11;
        bus.lsu_valid = 1'b1; bus.lsu_addr = 2; bus.lsu_data = 32'h22;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("rr_alu_ready%0d", k), bus.alu_ready, (k % 2 == 0));
            check($sformatf("rr_lsu_ready%0d", k), bus.lsu_ready, (k % 2 == 1));
            step();
            check($sformatf("rr_we%0d", k), bus.we_0, 1);
            check($sformatf("rr_addr%0d", k), bus.wr_addr0, (k % 2 == 0) ? 1 : 2);
            check($sformatf("rr_din%0d", k), bus.wr_din0,
                  (k % 2 == 0) ? 32'h11 : 32'h22);
        end
        idle_inputs();
        step();
        check("rr_we_off", bus.we_0, 0);

        // Scoreboard: reserve 7, LSU writes 7 two cycles later
        do_reset();
        bus.rsv_valid = 1'b1; bus.rsv_addr = 7;
        step();
        bus.rsv_valid = 1'b0;
        check("sb_set", bus.pending_mask, 32'h80);
        step();
        check("sb_hold", bus.pending_mask, 32'h80);
        bus.lsu_valid = 1'b1; bus.lsu_addr = 7; bus.lsu_data = 32'h77;
        #1;
        check("sb_lsu_ready", bus.lsu_ready, 1);
        step();
        bus.lsu_valid = 1'b0;
        check("sb_clear", bus.pending_mask, 0);
        check("sb_we", bus.we_0, 1);
        check("sb_addr", bus.wr_addr0, 7);
        // Same-edge reserve and ALU writeback of 7: set wins
        bus.rsv_valid = 1'b1; bus.rsv_addr = 7;
        bus.alu_valid = 1'b1; bus.alu_addr = 7; bus.alu_data = 32'h70;
        #1;
        check("sb_same_ready", bus.alu_ready, 1);
        step();
        check("sb_same_mask", bus.pending_mask, 32'h80);
        check("sb_same_noconf", bus.rsv_conflict, 0);
        // Re-reserve a pending register while it is being cleared: no conflict
        step();
        idle_inputs();
        check("sb_clr_noconf", bus.rsv_conflict, 0);
        check("sb_clr_mask", bus.pending_mask, 32'h80);

        // x0 write and x0 reservation
        bus.alu_valid = 1'b1; bus.alu_addr = 0; bus.alu_data = 32'h1234;
        #1;
        check("x0_ready", bus.alu_ready, 1);
        step();
        bus.alu_valid = 1'b0;
        check("x0_we", bus.we_0, 0);
        check("x0_mask", bus.pending_mask, 32'h80);
        bus.rsv_valid = 1'b1; bus.rsv_addr = 0;
        step();
        bus.rsv_valid = 1'b0;
        check("x0_rsv_mask", bus.pending_mask, 32'h80);
        check("x0_rsv_conf", bus.rsv_conflict, 0);

        // Double reservation of 3
        bus.rsv_valid = 1'b1; bus.rsv_addr = 3;
        step();
        check("dbl_first_conf", bus.rsv_conflict, 0);
        check("dbl_first_mask", bus.pending_mask, 32'h88);
        step();
        bus.rsv_valid = 1'b0;
        check("dbl_conf", bus.rsv_conflict, 1);
        check("dbl_mask", bus.pending_mask, 32'h88);
        step();
        check("dbl_conf_pulse", bus.rsv_conflict, 0);
        check("dbl_mask_keep", bus.pending_mask, 32'h88);

        // Stall with both valid
        bus.stall = 1'b1;
        bus.alu_valid = 1'b1; bus.alu_addr = 9;  bus.alu_data = 32'h99;
        bus.lsu_valid = 1'b1; bus.lsu_addr = 10; bus.lsu_data = 32'hAA;
        #1;
        check("stall_alu", bus.alu_ready, 0);
        check("stall_lsu", bus.lsu_ready, 0);
        step();
        check("stall_we", bus.we_0, 0);
        check("stall_mask", bus.pending_mask, 32'h88);

        // Asynchronous reset mid-cycle with pending bits set
        bus.stall = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("arst_mask", bus.pending_mask, 0);
        check("arst_we", bus.we_0, 0);
        check("arst_addr", bus.wr_addr0, 0);
        check("arst_din", bus.wr_din0, 0);
        check("arst_alu_ready", bus.alu_ready, 0);
        step();
        rst = 1'b0;
        #1;
        check("post_alu_ready", bus.alu_ready, 1);
        check("post_lsu_ready", bus.lsu_ready, 0);
        step();
        check("post_addr", bus.wr_addr0, 9);
        check("post_we", bus.we_0, 1);
        idle_inputs();
        step();

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
